// File: rtl/weight_loader_if.sv
// Byte-stream load channel and weight/bias read channel of the weight loader.
// The master drives the stream and the read addresses; the slave stores the model and returns reads.
interface weight_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        load_start;
  logic [12:0] weight_addr;
  logic [7:0]  weight_data;
  logic [3:0]  bias_addr;
  logic [31:0] bias_data;
  logic        weights_ready;
  logic        loading;

  modport master (
    output rx_data, rx_valid, load_start, weight_addr, bias_addr,
    input  weight_data, bias_data, weights_ready, loading
  );

  modport slave (
    input  rx_data, rx_valid, load_start, weight_addr, bias_addr,
    output weight_data, bias_data, weights_ready, loading
  );
endinterface

// File: rtl/weight_loader.sv
// Receives a classifier model (weight bytes, then little-endian 32-bit biases) from a byte
// stream and serves registered single-cycle reads of both memories to the inference engine.
module weight_loader #(
  parameter int NUM_WEIGHTS = 7840,
  parameter int NUM_BIASES  = 10
) (
  input  logic            clk,
  input  logic            rst,
  weight_loader_if.slave  bus
);

  localparam logic [12:0] W_LAST = 13'(NUM_WEIGHTS - 1);
  localparam logic [3:0]  B_LAST = 4'(NUM_BIASES - 1);

  typedef enum logic [1:0] {
    RECV_WEIGHTS = 2'd0,
    RECV_BIAS    = 2'd1,
    READY        = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        w_we_s;
  logic        b_we_s;
  logic [12:0] w_cnt_r;
  logic [3:0]  b_cnt_r;
  logic [1:0]  byte_sel_r;
  logic [31:0] asm_r;
  logic        weights_ready_r;
  logic        loading_r;
  logic [7:0]  weight_data_r;
  logic [31:0] bias_data_r;

  logic [7:0]  weight_mem [NUM_WEIGHTS];
  logic [31:0] bias_mem   [NUM_BIASES];

  // Next-state and write-enable decode; load_start overrides any stream byte.
  always_comb begin
    state_nxt_s = state_r;
    w_we_s      = 1'b0;
    b_we_s      = 1'b0;
    if (bus.load_start) begin
      state_nxt_s = RECV_WEIGHTS;
    end else begin
      case (state_r)
        RECV_WEIGHTS: begin
          if (bus.rx_valid) begin
            w_we_s = 1'b1;
            if (w_cnt_r == W_LAST) begin
              state_nxt_s = RECV_BIAS;
            end else begin
              state_nxt_s = RECV_WEIGHTS;
            end
          end else begin
            state_nxt_s = RECV_WEIGHTS;
          end
        end
        RECV_BIAS: begin
          if (bus.rx_valid && (byte_sel_r == 2'd3)) begin
            b_we_s = 1'b1;
            if (b_cnt_r == B_LAST) begin
              state_nxt_s = READY;
            end else begin
              state_nxt_s = RECV_BIAS;
            end
          end else begin
            state_nxt_s = RECV_BIAS;
          end
        end
        READY:   state_nxt_s = READY;
        default: state_nxt_s = RECV_WEIGHTS;
      endcase
    end
  end

  // State register; status flags follow the next state so they settle with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= RECV_WEIGHTS;
      weights_ready_r <= 1'b0;
      loading_r       <= 1'b1;
    end else begin
      state_r         <= state_nxt_s;
      weights_ready_r <= (state_nxt_s == READY);
      loading_r       <= (state_nxt_s != READY);
    end
  end

  // Stream counters and bias assembly; counters saturate at their last index.
  always_ff @(posedge clk) begin
    if (rst || bus.load_start) begin
      w_cnt_r    <= 13'd0;
      b_cnt_r    <= 4'd0;
      byte_sel_r <= 2'd0;
      asm_r      <= 32'd0;
    end else begin
      if (w_we_s) begin
        if (w_cnt_r == W_LAST) begin
          b_cnt_r    <= 4'd0;
          byte_sel_r <= 2'd0;
        end else begin
          w_cnt_r <= w_cnt_r + 13'd1;
        end
      end
      if ((state_r == RECV_BIAS) && bus.rx_valid) begin
        case (byte_sel_r)
          2'd0:    asm_r[7:0]   <= bus.rx_data;
          2'd1:    asm_r[15:8]  <= bus.rx_data;
          2'd2:    asm_r[23:16] <= bus.rx_data;
          2'd3:    asm_r[31:24] <= bus.rx_data;
          default: asm_r        <= asm_r;
        endcase
        byte_sel_r <= byte_sel_r + 2'd1;
        if (b_we_s && (b_cnt_r != B_LAST)) begin
          b_cnt_r <= b_cnt_r + 4'd1;
        end
      end
    end
  end

  // Memory write ports; no reset so both arrays map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_we_s) begin
      weight_mem[w_cnt_r] <= bus.rx_data;
    end
    if (b_we_s) begin
      bias_mem[b_cnt_r] <= {bus.rx_data, asm_r[23:0]};
    end
  end

  // Registered read ports; non-blocking write above gives read-first on collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_data_r <= 8'd0;
      bias_data_r   <= 32'd0;
    end else begin
      weight_data_r <= (bus.weight_addr <= W_LAST) ? weight_mem[bus.weight_addr] : 8'd0;
      bias_data_r   <= (bus.bias_addr <= B_LAST) ? bias_mem[bus.bias_addr] : 32'd0;
    end
  end

  assign bus.weight_data   = weight_data_r;
  assign bus.bias_data     = bias_data_r;
  assign bus.weights_ready = weights_ready_r;
  assign bus.loading       = loading_r;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: streams models with random gaps and compares reads
// against a byte-position reference model of the stream format.
module tb_weight_loader;

  localparam int NW    = 7840;
  localparam int NB    = 10;
  localparam int TOTAL = NW + 4 * NB;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  weight_loader_if bus ();

  weight_loader #(.NUM_WEIGHTS(NW), .NUM_BIASES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: stream position decides where each byte goes.
  logic [7:0]  ref_w [NW];
  logic [31:0] ref_b [NB];
  logic [31:0] ref_asm;
  int          pos;
  bit          ref_ready;

  function automatic void model_restart();
    pos       = 0;
    ref_ready = 1'b0;
    ref_asm   = 32'd0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    int lane;
    if (ref_ready) return;
    if (pos < NW) begin
      ref_w[pos] = b;
    end else begin
      k    = (pos - NW) / 4;
      lane = (pos - NW) % 4;
      ref_asm[lane*8 +: 8] = b;
      if (lane == 3) ref_b[k] = ref_asm;
    end
    pos++;
    if (pos == TOTAL) ref_ready = 1'b1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    if ($urandom_range(0, 15) == 0) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    model_byte(b);
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_load_start();
    @(negedge clk);
    bus.rx_valid   = 1'b0;
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
    model_restart();
  endtask

  task automatic read_w(input logic [12:0] a, output logic [7:0] v);
    @(negedge clk);
    bus.weight_addr = a;
    @(negedge clk);
    v = bus.weight_data;
  endtask

  task automatic read_b(input logic [3:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.bias_addr = a;
    @(negedge clk);
    v = bus.bias_data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (bus.weights_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", bus.weights_ready); end
    if (bus.loading !== 1'b1) begin n_err++; $display("FAIL reset_loading got %b want 1", bus.loading); end
    if (bus.weight_data !== 8'h00) begin n_err++; $display("FAIL reset_wdata got %h want 00", bus.weight_data); end
    if (bus.bias_data !== 32'h0) begin n_err++; $display("FAIL reset_bdata got %h want 0", bus.bias_data); end
    rst = 1'b0;
    model_restart();
  endtask

  task automatic test_full_load();
    logic [7:0]  v;
    logic [31:0] bv;
    logic [12:0] a;
    for (int i = 0; i < NW; i++) send_byte(8'(i % 256));
    for (int k = 0; k < NB; k++) begin
      bv = 32'h01020300 + 32'(k);
      for (int j = 0; j < 4; j++) begin
        if (k == NB - 1 && j == 3) begin
          n_cmp += 2;
          if (bus.weights_ready !== 1'b0) begin n_err++; $display("FAIL early_ready got %b want 0", bus.weights_ready); end
          if (bus.loading !== 1'b1) begin n_err++; $display("FAIL mid_loading got %b want 1", bus.loading); end
        end
        send_byte(bv[j*8 +: 8]);
      end
    end
    end_stream();
    n_cmp += 2;
    if (bus.weights_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_load got %b want 1", bus.weights_ready); end
    if (bus.loading !== 1'b0) begin n_err++; $display("FAIL loading_after_load got %b want 0", bus.loading); end
    read_w(13'd0, v);    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL w0 got %h want 00", v); end
    read_w(13'd783, v);  n_cmp++; if (v !== 8'h0F) begin n_err++; $display("FAIL w783 got %h want 0f", v); end
    read_w(13'd7839, v); n_cmp++; if (v !== 8'h9F) begin n_err++; $display("FAIL w7839 got %h want 9f", v); end
    read_b(4'd9, bv);    n_cmp++; if (bv !== 32'h01020309) begin n_err++; $display("FAIL b9 got %h want 01020309", bv); end
    for (int r = 0; r < 12; r++) begin
      a = 13'($urandom_range(0, NW - 1));
      read_w(a, v);
      n_cmp++;
      if (v !== ref_w[a]) begin n_err++; $display("FAIL rand_w[%0d] got %h want %h", a, v, ref_w[a]); end
    end
  endtask

  task automatic test_bias_order();
    logic [7:0]  v;
    logic [31:0] bv;
    logic [12:0] a;
    pulse_load_start();
    for (int i = 0; i < NW; i++) send_byte(8'($urandom));
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    send_byte(8'h85); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    for (int i = 8; i < 4 * NB; i++) send_byte(8'($urandom));
    end_stream();
    read_b(4'd0, bv); n_cmp++; if (bv !== 32'hDEADBEEF) begin n_err++; $display("FAIL b0_order got %h want deadbeef", bv); end
    read_b(4'd1, bv); n_cmp++; if (bv !== 32'hFFFFFF85) begin n_err++; $display("FAIL b1_negative got %h want ffffff85", bv); end
    for (int k = 2; k < NB; k++) begin
      read_b(4'(k), bv);
      n_cmp++;
      if (bv !== ref_b[k]) begin n_err++; $display("FAIL rand_b[%0d] got %h want %h", k, bv, ref_b[k]); end
    end
    for (int r = 0; r < 8; r++) begin
      a = 13'($urandom_range(0, NW - 1));
      read_w(a, v);
      n_cmp++;
      if (v !== ref_w[a]) begin n_err++; $display("FAIL rand_w2[%0d] got %h want %h", a, v, ref_w[a]); end
    end
  endtask

  task automatic test_extra_bytes();
    logic [7:0]  v;
    logic [31:0] bv;
    for (int i = 0; i < 20; i++) send_byte(8'h55);
    end_stream();
    n_cmp++;
    if (bus.weights_ready !== 1'b1) begin n_err++; $display("FAIL extra_ready got %b want 1", bus.weights_ready); end
    read_w(13'd0, v); n_cmp++; if (v !== ref_w[0]) begin n_err++; $display("FAIL extra_w0 got %h want %h", v, ref_w[0]); end
    read_b(4'd0, bv); n_cmp++; if (bv !== ref_b[0]) begin n_err++; $display("FAIL extra_b0 got %h want %h", bv, ref_b[0]); end
  endtask

  task automatic test_restart();
    logic [7:0] v;
    pulse_load_start();
    for (int i = 0; i < 5000; i++) send_byte(8'($urandom));
    end_stream();
    n_cmp += 2;
    if (bus.weights_ready !== 1'b0) begin n_err++; $display("FAIL partial_ready got %b want 0", bus.weights_ready); end
    if (bus.loading !== 1'b1) begin n_err++; $display("FAIL partial_loading got %b want 1", bus.loading); end
    pulse_load_start();
    for (int i = 0; i < TOTAL; i++) begin
      send_byte(8'hAA);
      if (i == NW) begin
        n_cmp++;
        if (bus.weights_ready !== 1'b0) begin n_err++; $display("FAIL reload_mid_ready got %b want 0", bus.weights_ready); end
      end
    end
    end_stream();
    n_cmp++;
    if (bus.weights_ready !== 1'b1) begin n_err++; $display("FAIL reload_ready got %b want 1", bus.weights_ready); end
    read_w(13'd0, v);    n_cmp++; if (v !== 8'hAA) begin n_err++; $display("FAIL reload_w0 got %h want aa", v); end
    read_w(13'd7839, v); n_cmp++; if (v !== 8'hAA) begin n_err++; $display("FAIL reload_w7839 got %h want aa", v); end
  endtask

  task automatic test_coincident();
    logic [7:0] v;
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.rx_valid   = 1'b1;
    bus.rx_data    = 8'h77;
    model_restart();
    @(negedge clk);
    bus.load_start = 1'b0;
    bus.rx_valid   = 1'b0;
    send_byte(8'h11);
    for (int i = 1; i < TOTAL; i++) send_byte(8'($urandom));
    end_stream();
    read_w(13'd0, v); n_cmp++; if (v !== 8'h11) begin n_err++; $display("FAIL coinc_w0 got %h want 11", v); end
    read_w(13'd1, v); n_cmp++; if (v !== ref_w[1]) begin n_err++; $display("FAIL coinc_w1 got %h want %h", v, ref_w[1]); end
    n_cmp++;
    if (bus.weights_ready !== 1'b1) begin n_err++; $display("FAIL coinc_ready got %b want 1", bus.weights_ready); end
  endtask

  task automatic test_out_of_range();
    logic [7:0]  v;
    logic [31:0] bv;
    read_w(13'd8000, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL oor_w8000 got %h want 00", v); end
    read_w(13'd7840, v); n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL oor_w7840 got %h want 00", v); end
    read_w(13'd7839, v); n_cmp++; if (v !== ref_w[7839]) begin n_err++; $display("FAIL edge_w7839 got %h want %h", v, ref_w[7839]); end
    read_b(4'd12, bv);   n_cmp++; if (bv !== 32'h0) begin n_err++; $display("FAIL oor_b12 got %h want 0", bv); end
    read_b(4'd10, bv);   n_cmp++; if (bv !== 32'h0) begin n_err++; $display("FAIL oor_b10 got %h want 0", bv); end
    read_b(4'd9, bv);    n_cmp++; if (bv !== ref_b[9]) begin n_err++; $display("FAIL edge_b9 got %h want %h", bv, ref_b[9]); end
  endtask

  task automatic test_reset_mid_bias();
    pulse_load_start();
    for (int i = 0; i < NW + 6; i++) send_byte(8'($urandom));
    @(negedge clk);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp += 2;
    if (bus.weights_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready got %b want 0", bus.weights_ready); end
    if (bus.loading !== 1'b1) begin n_err++; $display("FAIL rst_mid_loading got %b want 1", bus.loading); end
    rst = 1'b0;
    model_restart();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.weights_ready !== 1'b0) begin n_err++; $display("FAIL post_rst_ready got %b want 0", bus.weights_ready); end
  endtask

  initial begin
    rst             = 1'b1;
    bus.rx_data     = 8'h00;
    bus.rx_valid    = 1'b0;
    bus.load_start  = 1'b0;
    bus.weight_addr = 13'd0;
    bus.bias_addr   = 4'd0;
    model_restart();
    test_reset();
    test_full_load();
    test_bias_order();
    test_extra_bytes();
    test_restart();
    test_coincident();
    test_out_of_range();
    test_reset_mid_bias();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter NUM_WEIGHTS, default 7840, weight bytes per model (10 classes x 784 pixels).
REQ-002 Parameter NUM_BIASES, default 10, 32-bit biases per model.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port rx_data  input  8  received byte, from the UART receiver.
REQ-006 Port rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-007 Port load_start  input  1  one-cycle pulse; discard the current model and restart the load.
REQ-008 Port weight_addr  input  13  weight read address, 0..NUM_WEIGHTS-1, driven by the inference engine.
REQ-009 Port weight_data  output  8  weight byte, registered, 1-cycle read latency.
REQ-010 Port bias_addr  input  4  bias read address, 0..NUM_BIASES-1.
REQ-011 Port bias_data  output  32  bias word, registered, 1-cycle read latency.
REQ-012 Port weights_ready  output  1  high while a complete model is stored.
REQ-013 Port loading  output  1  high while a model is being received.

Function
REQ-014 States: RECV_WEIGHTS, RECV_BIAS, READY; reset enters RECV_WEIGHTS.
REQ-015 Stream format: NUM_WEIGHTS weight bytes in address order, then NUM_BIASES biases, each as 4 bytes little-endian; no header, no checksum.
REQ-016 RECV_WEIGHTS: each rx_valid writes rx_data to weight memory at w_cnt, then increments w_cnt; the write with w_cnt = NUM_WEIGHTS-1 moves to RECV_BIAS and clears b_cnt and byte_sel.
REQ-017 RECV_BIAS: each rx_valid places the byte in lane byte_sel (0 = bits 7:0 ... 3 = bits 31:24) of the assembly register; byte_sel then wraps 3->0.
REQ-018 The 4th byte writes {rx_data, assembled[23:0]} to bias memory at b_cnt in the same cycle; b_cnt then increments.
REQ-019 The 4th byte with b_cnt = NUM_BIASES-1 moves to READY; weights_ready rises on the next cycle.
REQ-020 READY: rx_valid bytes are ignored; memory and state are unchanged.
REQ-021 load_start in any state: return to RECV_WEIGHTS; clear w_cnt, b_cnt, byte_sel and the assembly register; drop weights_ready on the next cycle.
REQ-022 load_start and rx_valid in the same cycle: load_start wins; the byte is discarded.
REQ-023 loading = (state != READY); weights_ready = (state == READY); both registered.
REQ-024 Reads: weight_data <= mem[weight_addr] and bias_data <= mem[bias_addr] every cycle, in all states.
REQ-025 Read address out of range (weight_addr >= NUM_WEIGHTS or bias_addr >= NUM_BIASES): the output registers 0.
REQ-026 Read and write to the same address in the same cycle: the read returns the old contents (read-first).
REQ-027 Weight memory is 8-bit x NUM_WEIGHTS and bias memory is 32-bit x NUM_BIASES, both inferable as block RAM; byte values are stored unmodified, interpreted as two's-complement by the consumer.
REQ-028 Counters never exceed their range; no wrap past NUM_WEIGHTS-1 or NUM_BIASES-1 is possible.

Reset
REQ-029 rst: state = RECV_WEIGHTS, w_cnt = 0, b_cnt = 0, byte_sel = 0, assembly register = 0, weights_ready = 0, loading = 1, weight_data = 0, bias_data = 0.
REQ-030 Memory contents are not cleared by reset; reads before the first completed load are undefined and unchecked.
REQ-031 rst during a load aborts it; the sender must restart the stream from byte 0.

Verification
REQ-032 Full load with weight[i] = i mod 256 and bias[k] = 0x01020300+k; then read weight 0, 783 and 7839 -> 0x00, 0x0F, 0x9F one cycle after the address; bias 9 -> 0x01020309; weights_ready high one cycle after the last byte.
REQ-033 Bias byte order: bias 0 bytes 0xEF, 0xBE, 0xAD, 0xDE -> bias_data = 0xDEADBEEF; a negative bias 0xFFFFFF85 round-trips exactly.
REQ-034 Extra bytes after READY (send 0x55 x 20) -> weight 0 and bias 0 are unchanged; weights_ready stays 1.
REQ-035 load_start after 5000 weight bytes, then a full new stream of all 0xAA -> weight 0 and weight 7839 both read 0xAA; weights_ready low until the new load completes.
REQ-036 load_start coincident with an rx_valid byte -> the byte is not written; the next byte lands at weight address 0.
REQ-037 Out-of-range reads: weight_addr = 8000 -> 0x00, bias_addr = 12 -> 0x00000000; rst mid-bias-phase -> weights_ready = 0, loading = 1.
